solve_player: RTL and testbench

- Playback controller that replays a completed puzzle solution onto the board datapath, one move at a time.
- Latches the solver's move list (cnt, ord) when the solver signals completion.
- Issues each 2-bit move over a valid/ready handshake, either automatically at a fixed interval or one move per button press.
- Sits between the solver, the board-update datapath and the front-panel I/O; exports the current move index for display.

---
 rtl/solve_player_pkg.sv | 6 +
 rtl/solve_player_btn_edge.sv | 17 +
 rtl/solve_player.sv | 118 +++++++++++
 tb/tb_solve_player.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/solve_player_pkg.sv
// solve_player_pkg: shared move encoding, playback FSM states and move-list capacity
package solve_player_pkg;
  localparam int MAX_MOVES = 32;
  typedef enum logic [1:0] {UP = 2'b00, DOWN = 2'b01, LEFT = 2'b10, RIGHT = 2'b11} move_t;
  typedef enum logic [2:0] {IDLE, READY, ISSUE, GAP, DONE} state_t;
endpackage

// File: rtl/solve_player_btn_edge.sv
// btn_edge: 2-flop synchroniser plus registered rising-edge pulse for one raw button
module btn_edge (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic pulse
);
  logic [2:0] sync;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      sync <= '0;
      pulse <= 1'b0;
    end else begin
      sync <= {sync[1:0], btn};
      pulse <= sync[1] & ~sync[2];
    end
endmodule

// File: rtl/solve_player.sv
// solve_player: replays a latched solver move list onto the board over valid/ready
module solve_player #(
  parameter logic [23:0] STEP_DIV = 24'd12_000_000,
  parameter int MAX_MOVES = solve_player_pkg::MAX_MOVES
) (
  input  logic clk,
  input  logic rst,
  input  logic comp,
  input  logic [$clog2(MAX_MOVES+1)-1:0] cnt,
  input  logic [2*MAX_MOVES-1:0] ord,
  input  logic btn_play,
  input  logic btn_step,
  input  logic btn_rst,
  output logic [1:0] mv_dir,
  output logic mv_valid,
  input  logic mv_ready,
  output logic [$clog2(MAX_MOVES)-1:0] idx,
  output logic playing,
  output logic done
);
  import solve_player_pkg::*;
  localparam int IW = $clog2(MAX_MOVES);
  localparam int CW = $clog2(MAX_MOVES + 1);
  state_t state, state_n;
  logic [CW-1:0] n_r, n_n;
  logic [2*MAX_MOVES-1:0] ord_r, ord_n;
  logic [IW-1:0] idx_n;
  logic [23:0] gap_cnt, gap_n;
  logic playing_n, rst_pend, pend_n, comp_q;
  logic p_play, p_step, p_rst, hs, last;
  btn_edge u_play (.clk(clk), .rst(rst), .btn(btn_play), .pulse(p_play));
  btn_edge u_step (.clk(clk), .rst(rst), .btn(btn_step), .pulse(p_step));
  btn_edge u_rst  (.clk(clk), .rst(rst), .btn(btn_rst),  .pulse(p_rst));
  assign mv_valid = state == ISSUE;
  assign mv_dir = mv_valid ? ord_r[{idx, 1'b0} +: 2] : 2'b00;
  assign done = state == DONE;
  assign hs = mv_valid & mv_ready;
  assign last = (CW'(idx) + CW'(1)) == n_r;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      n_r <= '0;
      ord_r <= '0;
      idx <= '0;
      playing <= 1'b0;
      gap_cnt <= '0;
      rst_pend <= 1'b0;
      comp_q <= 1'b0;
    end else begin
      state <= state_n;
      n_r <= n_n;
      ord_r <= ord_n;
      idx <= idx_n;
      playing <= playing_n;
      gap_cnt <= gap_n;
      rst_pend <= pend_n;
      comp_q <= comp;
    end
  always_comb begin
    state_n = state;
    n_n = n_r;
    ord_n = ord_r;
    idx_n = idx;
    playing_n = playing;
    gap_n = gap_cnt;
    pend_n = rst_pend;
    case (state)
      IDLE:
        if (comp & ~comp_q) begin
          n_n = cnt;
          ord_n = ord;
          idx_n = '0;
          playing_n = 1'b0;
          state_n = cnt == '0 ? DONE : READY;
        end
      READY: begin
        playing_n = p_play;
        state_n = (p_play | p_step) ? ISSUE : READY;
      end
      ISSUE: begin
        pend_n = rst_pend | p_rst;
        playing_n = playing & ~p_play;
        if (mv_ready) begin
          pend_n = 1'b0;
          if (last) begin
            playing_n = 1'b0;
            state_n = DONE;
          end else begin
            idx_n = idx + 1'b1;
            gap_n = STEP_DIV - 24'd1;
            state_n = playing_n ? (STEP_DIV == 24'd1 ? ISSUE : GAP) : READY;
          end
        end
      end
      GAP:
        if (p_play) begin
          playing_n = 1'b0;
          state_n = READY;
        end else if (gap_cnt == 24'd1) state_n = ISSUE;
        else gap_n = gap_cnt - 24'd1;
      DONE: playing_n = 1'b0;
      default: state_n = IDLE;
    endcase
    if ((p_rst & (state == READY | state == GAP | state == DONE)) | (hs & (rst_pend | p_rst))) begin
      idx_n = '0;
      playing_n = 1'b0;
      state_n = n_r == '0 ? DONE : READY;
    end
    if (state != IDLE & ~comp & (state != ISSUE | hs)) begin
      state_n = IDLE;
      n_n = '0;
      ord_n = '0;
      idx_n = '0;
      playing_n = 1'b0;
      pend_n = 1'b0;
    end
  end
endmodule

// File: tb/tb_solve_player.sv
// tb_solve_player: randomized scoreboard bench for solve_player against a move-list model
module tb_solve_player;
  localparam logic [23:0] SD = 24'd4;
  logic clk = 1'b0, rst = 1'b1, comp = 1'b0, mv_ready = 1'b1;
  logic btn_play = 1'b0, btn_step = 1'b0, btn_rst = 1'b0;
  logic [5:0] cnt = '0;
  logic [63:0] ord = '0;
  logic [1:0] mv_dir;
  logic [4:0] idx;
  logic mv_valid, playing, done;
  typedef struct {logic [1:0] dir; int idx;} exp_t;
  exp_t exp_q[$];
  int passed = 0, total = 0, cyc = 0, acc_cnt = 0, last_acc = -100, gap_base = 0;
  int m_c = 0;
  logic [63:0] m_o = '0;
  bit chk_gap = 0;
  solve_player #(.STEP_DIV(SD)) dut (
    .clk(clk), .rst(rst), .comp(comp), .cnt(cnt), .ord(ord),
    .btn_play(btn_play), .btn_step(btn_step), .btn_rst(btn_rst),
    .mv_dir(mv_dir), .mv_valid(mv_valid), .mv_ready(mv_ready),
    .idx(idx), .playing(playing), .done(done)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string name, input longint act, input longint exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic fill(input int c, input logic [63:0] o);
    exp_q.delete();
    for (int i = 0; i < c; i++) exp_q.push_back('{dir: 2'((o >> (2 * i)) & 64'd3), idx: i});
  endtask
  task automatic load(input int c, input logic [63:0] o);
    comp = 1'b0;
    tick(2);
    cnt = 6'(c);
    ord = o;
    comp = 1'b1;
    m_c = c;
    m_o = o;
    fill(c, o);
    tick(2);
  endtask
  task automatic press(input int b);
    if (b == 0) btn_play = 1'b1;
    else if (b == 1) btn_step = 1'b1;
    else btn_rst = 1'b1;
    tick(5);
    btn_play = 1'b0;
    btn_step = 1'b0;
    btn_rst = 1'b0;
    tick(5);
  endtask
  task automatic wait_acc(input int target, input int budget, input string name);
    int k = 0;
    while (acc_cnt < target && k < budget) begin
      @(negedge clk);
      #1;
      k++;
    end
    chk(name, acc_cnt, target);
  endtask
  always @(negedge clk) begin
    exp_t e;
    if (!rst && mv_valid && mv_ready) begin
      if (exp_q.size() == 0) begin
        total++;
        $display("FAIL unexpected_accept: idx %0d dir %0d, expected no move", idx, mv_dir);
      end else begin
        e = exp_q.pop_front();
        chk("acc_dir", mv_dir, e.dir);
        chk("acc_idx", idx, e.idx);
      end
      if (chk_gap && last_acc >= gap_base) chk("accept_spacing", cyc - last_acc, SD);
      last_acc = cyc;
      acc_cnt++;
    end
  end
  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running, expected finish");
    $fatal(1);
  end
  initial begin
    logic [1:0] d0;
    logic [4:0] i0;
    logic [63:0] r;
    int base, c;
    tick(2);
    chk("rst_mv_valid", mv_valid, 0);
    chk("rst_mv_dir", mv_dir, 0);
    chk("rst_idx", idx, 0);
    chk("rst_playing", playing, 0);
    chk("rst_done", done, 0);
    rst = 1'b0;
    tick(2);
    load(3, 64'h39);
    chk("step_idx0", idx, 0);
    press(1);
    chk("step_idx1", idx, 1);
    press(1);
    chk("step_idx2", idx, 2);
    press(1);
    chk("step_idx_hold", idx, 2);
    chk("step_done", done, 1);
    chk("step_q_empty", exp_q.size(), 0);
    base = acc_cnt;
    press(1);
    tick(5);
    chk("step_extra_none", acc_cnt, base);
    chk("step_extra_valid", mv_valid, 0);
    r = {$urandom, $urandom};
    load(4, r);
    mv_ready = 1'b0;
    press(1);
    chk("bp_valid", mv_valid, 1);
    d0 = mv_dir;
    i0 = idx;
    chk("bp_dir_model", d0, exp_q[0].dir);
    for (int i = 0; i < 10; i++) begin
      tick(1);
      chk("bp_stable", {mv_valid, mv_dir, idx}, {1'b1, d0, i0});
    end
    base = acc_cnt;
    mv_ready = 1'b1;
    wait_acc(base + 1, 10, "bp_accept");
    tick(2);
    chk("bp_idx", idx, 1);
    chk("bp_paused", mv_valid, 0);
    mv_ready = 1'b0;
    press(1);
    press(2);
    chk("rstdef_valid", mv_valid, 1);
    chk("rstdef_idx", idx, 1);
    base = acc_cnt;
    mv_ready = 1'b1;
    wait_acc(base + 1, 10, "rstdef_accept");
    fill(m_c, m_o);
    tick(2);
    chk("rstdef_idx0", idx, 0);
    chk("rstdef_valid_off", mv_valid, 0);
    chk("rstdef_done", done, 0);
    press(1);
    chk("rstdef_replay_idx", idx, 1);
    r = {$urandom, $urandom};
    load(5, r);
    gap_base = cyc;
    chk_gap = 1;
    base = acc_cnt;
    press(0);
    chk("auto_playing", playing, 1);
    wait_acc(base + 5, 100, "auto_accepts");
    tick(2);
    chk("auto_done", done, 1);
    chk("auto_playing_off", playing, 0);
    chk_gap = 0;
    r = {$urandom, $urandom};
    load(6, r);
    base = acc_cnt;
    btn_play = 1'b1;
    wait_acc(base + 2, 60, "gaprst_two");
    btn_play = 1'b0;
    btn_rst = 1'b1;
    tick(5);
    btn_rst = 1'b0;
    fill(m_c, m_o);
    tick(10);
    chk("gaprst_no_third", acc_cnt, base + 2);
    chk("gaprst_idx", idx, 0);
    chk("gaprst_playing", playing, 0);
    chk("gaprst_valid", mv_valid, 0);
    press(1);
    chk("gaprst_replay_idx", idx, 1);
    comp = 1'b0;
    exp_q.delete();
    tick(3);
    chk("compdrop_valid", mv_valid, 0);
    chk("compdrop_idx", idx, 0);
    base = acc_cnt;
    press(1);
    chk("compdrop_idle", acc_cnt, base);
    load(0, r);
    chk("cnt0_done", done, 1);
    base = acc_cnt;
    press(0);
    press(1);
    press(2);
    tick(5);
    chk("cnt0_no_accept", acc_cnt, base);
    chk("cnt0_playing", playing, 0);
    chk("cnt0_still_done", done, 1);
    r = {$urandom, $urandom};
    load(32, r);
    gap_base = cyc;
    chk_gap = 1;
    base = acc_cnt;
    press(0);
    wait_acc(base + 32, 400, "full_accepts");
    tick(2);
    chk("full_idx_sat", idx, 31);
    chk("full_done", done, 1);
    chk("full_playing", playing, 0);
    chk_gap = 0;
    for (int t = 0; t < 4; t++) begin
      c = $urandom_range(1, 10);
      r = {$urandom, $urandom};
      mv_ready = 1'b1;
      load(c, r);
      base = acc_cnt;
      press(0);
      for (int k = 0; k < 400 && acc_cnt < base + c; k++) begin
        @(posedge clk);
        #1;
        mv_ready = 1'($urandom_range(0, 1));
      end
      mv_ready = 1'b1;
      wait_acc(base + c, 20, "rand_accepts");
      tick(2);
      chk("rand_done", done, 1);
      chk("rand_q_empty", exp_q.size(), 0);
    end
    r = {$urandom, $urandom};
    load(3, r);
    mv_ready = 1'b0;
    press(1);
    chk("arst_valid_before", mv_valid, 1);
    #2 rst = 1'b1;
    #1;
    chk("arst_mv_valid", mv_valid, 0);
    chk("arst_mv_dir", mv_dir, 0);
    chk("arst_idx", idx, 0);
    chk("arst_playing", playing, 0);
    chk("arst_done", done, 0);
    exp_q.delete();
    comp = 1'b0;
    tick(2);
    rst = 1'b0;
    tick(2);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
